cic3_interp: RTL and testbench

- Third-order cascaded integrator-comb interpolator (N=3, M=1); the upsampling counterpart of the shared-divider CIC3 decimator.
- Accepts low-rate signed samples once every INTERP_FACTOR clk cycles through a valid/ready handshake.
- Emits one full-precision signed sample on every clk cycle.
- Drives the high-rate test DAC/modulator path. The combs run at the low rate; the integrators run at the clk rate.

---
 rtl/cic3_pkg.sv | 18 +
 rtl/cic3_rate_gen.sv | 30 +++
 rtl/cic3_interp.sv | 131 +++++++++++++
 tb/tb_cic3_interp.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cic3_pkg.sv
// Shared definitions for the CIC3 interpolator and decimator datapaths.
// Holds the filter order, output-width helper and accumulator type.
package cic3_pkg;

  localparam int CIC_ORDER  = 3;
  localparam int CIC_IN_W   = 16;
  localparam int CIC_RATE_W = 8;

  // Full-precision width: input plus (N-1)*log2(R) growth bits.
  function automatic int cic_out_width(input int in_w, input int rate_w);
    return in_w + (CIC_ORDER - 1) * rate_w;
  endfunction

  localparam int CIC_ACC_W = cic_out_width(CIC_IN_W, CIC_RATE_W);

  typedef logic signed [CIC_ACC_W-1:0] cic_acc_t;

endpackage

// File: rtl/cic3_rate_gen.sv
// Phase counter for CIC3 interpolators: slot strobe on the last phase,
// phase0 strobe on the first, both gated by enable.
module cic3_rate_gen
  import cic3_pkg::*;
#(
  parameter int RATE_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic slot,
  output logic phase0
);

  logic [RATE_WIDTH-1:0] phase;

  // Free-running counter; parked at 0 while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      phase <= '0;
    else if (!enable)
      phase <= '0;
    else
      phase <= phase + RATE_WIDTH'(1);
  end

  assign slot   = enable && (phase == {RATE_WIDTH{1'b1}});
  assign phase0 = enable && (phase == '0);

endmodule

// File: rtl/cic3_interp.sv
// Third-order CIC interpolator: combs at the slot rate, integrators at clk.
// Optional macro CIC3_INTERP_UNDERFLOW_CNT_EN adds a saturating miss counter.
module cic3_interp
  import cic3_pkg::*;
#(
  parameter int INTERP_FACTOR = 256,
  parameter int RATE_WIDTH    = $clog2(INTERP_FACTOR),
  parameter int IN_WIDTH      = 16,
  parameter int OUT_WIDTH     = cic_out_width(IN_WIDTH, RATE_WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic                 underflow
`ifdef CIC3_INTERP_UNDERFLOW_CNT_EN
  ,
  output logic [7:0]           underflow_count
`endif
);

  localparam int EXT = OUT_WIDTH - IN_WIDTH;

  logic slot;
  logic phase0;
  logic miss;

  logic signed [OUT_WIDTH-1:0] x;
  logic signed [OUT_WIDTH-1:0] c1, c2, c3;
  logic signed [OUT_WIDTH-1:0] x_d, c1_d, c2_d;
  logic signed [OUT_WIDTH-1:0] comb_out_q;
  logic signed [OUT_WIDTH-1:0] u;
  logic signed [OUT_WIDTH-1:0] i1, i2, i3;

  cic3_rate_gen #(
    .RATE_WIDTH(RATE_WIDTH)
  ) u_rate (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .slot  (slot),
    .phase0(phase0)
  );

  assign in_ready = slot;
  assign miss     = slot && !in_valid;

  // Missing sample is replaced by zero; otherwise sign-extend.
  always_comb begin
    x = '0;
    if (in_valid)
      x = {{EXT{in_data[IN_WIDTH-1]}}, in_data};
  end

  assign c1 = x  - x_d;
  assign c2 = c1 - c1_d;
  assign c3 = c2 - c2_d;

  // Comb delays and comb output advance only on slot edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_d        <= '0;
      c1_d       <= '0;
      c2_d       <= '0;
      comb_out_q <= '0;
    end else if (!enable) begin
      x_d        <= '0;
      c1_d       <= '0;
      c2_d       <= '0;
      comb_out_q <= '0;
    end else if (slot) begin
      x_d        <= x;
      c1_d       <= c1;
      c2_d       <= c2;
      comb_out_q <= c3;
    end
  end

  // Zero-stuff: the comb result enters only on phase 0.
  assign u = phase0 ? comb_out_q : '0;

  // Integrator cascade at the clk rate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i1 <= '0;
      i2 <= '0;
      i3 <= '0;
    end else if (!enable) begin
      i1 <= '0;
      i2 <= '0;
      i3 <= '0;
    end else begin
      i1 <= i1 + u;
      i2 <= i2 + i1;
      i3 <= i3 + i2;
    end
  end

  assign out_data = i3;

  // Output is valid on every edge taken while enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      out_valid <= 1'b0;
    else
      out_valid <= enable;
  end

  // Sticky miss flag survives enable drops; reset only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      underflow <= 1'b0;
    else if (miss)
      underflow <= 1'b1;
  end

`ifdef CIC3_INTERP_UNDERFLOW_CNT_EN
  // Saturating count of missed slots.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      underflow_count <= '0;
    else if (miss && underflow_count != 8'hFF)
      underflow_count <= underflow_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_cic3_interp.sv
// Scoreboard bench for cic3_interp: R=4 random/step/impulse runs against
// a convolution model, plus an R=256 full-scale DC check.
module tb_cic3_interp;

  localparam int R   = 4;
  localparam int IW  = 16;
  localparam int OW  = 20;
  localparam int HL  = 3 * R - 2;
  localparam int R2  = 256;
  localparam int OW2 = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset = 1'b1;
  logic                 enable = 1'b0;
  logic [IW-1:0]        in_data = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [OW-1:0] out_data;
  logic                 out_valid;
  logic                 underflow;
  logic [7:0]           ucnt;

  logic                  en2 = 1'b0;
  logic [IW-1:0]         d2 = '0;
  logic                  v2 = 1'b0;
  logic                  rdy2;
  logic signed [OW2-1:0] out2;
  logic                  ov2;
  logic                  uf2;
  logic [7:0]            ucnt2;

  cic3_interp #(.INTERP_FACTOR(R), .IN_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .underflow(underflow)
`ifdef CIC3_INTERP_UNDERFLOW_CNT_EN
    , .underflow_count(ucnt)
`endif
  );

  cic3_interp #(.INTERP_FACTOR(R2), .IN_WIDTH(IW)) dut2 (
    .clk(clk), .reset(reset), .enable(en2),
    .in_data(d2), .in_valid(v2), .in_ready(rdy2),
    .out_data(out2), .out_valid(ov2), .underflow(uf2)
`ifdef CIC3_INTERP_UNDERFLOW_CNT_EN
    , .underflow_count(ucnt2)
`endif
  );

`ifndef CIC3_INTERP_UNDERFLOW_CNT_EN
  assign ucnt  = '0;
  assign ucnt2 = '0;
`endif

  int errors = 0;
  int checks = 0;

  logic signed [OW-1:0] exp_q[$];
  int  h[HL];
  int  e = 0;
  int  smp_k[$];
  int  smp_x[$];
  bit  uf_m = 1'b0;

  longint mon_sum = 0;
  int     mon_n = 0;
  int     first_nz = -1;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Impulse response of three cascaded length-R boxcars.
  initial begin
    for (int n = 0; n < HL; n++) h[n] = 0;
    for (int a = 0; a < R; a++)
      for (int b = 0; b < R; b++)
        for (int c = 0; c < R; c++)
          h[a + b + c]++;
  end

  // Monitor: pop and compare whenever the DUT presents a sample.
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 1, 0);
      end else begin
        chk("out_data", out_data, exp_q.pop_front());
      end
      mon_sum += out_data;
      if (first_nz < 0 && out_data != 0) first_nz = mon_n;
      mon_n++;
    end
  end

  task automatic model_clear();
    e = 0;
    smp_k.delete();
    smp_x.delete();
  endtask

  // One clk cycle on the R=4 instance; predicts the output of this edge.
  task automatic cycle(input bit en, input bit v, input int d);
    longint y;
    logic signed [OW-1:0] yt;
    @(negedge clk);
    enable   = en;
    in_valid = v;
    in_data  = d[IW-1:0];
    #1;
    chk("in_ready", in_ready, en && (e % R == R - 1));
    chk("underflow", underflow, uf_m);
    if (en) begin
      if (e % R == R - 1) begin
        smp_k.push_back(e);
        smp_x.push_back(v ? d : 0);
        if (!v) uf_m = 1'b1;
      end
      while (smp_k.size() > 0 && e - (smp_k[0] + 3) >= HL) begin
        void'(smp_k.pop_front());
        void'(smp_x.pop_front());
      end
      y = 0;
      foreach (smp_k[j]) begin
        int n;
        n = e - (smp_k[j] + 3);
        if (n >= 0 && n < HL) y += longint'(smp_x[j]) * h[n];
      end
      yt = y[OW-1:0];
      exp_q.push_back(yt);
      e++;
    end else begin
      model_clear();
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_underflow", underflow, 0);
    enable   = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    model_clear();
    uf_m = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    chk("init_out_data", out_data, 0);
    chk("init_out_valid", out_valid, 0);
    chk("init_in_ready", in_ready, 0);
    chk("init_underflow", underflow, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Step response.
    cycle(1, 1, 1);
    #1 chk("out_valid_first", out_valid, 1);
    repeat (40) cycle(1, 1, 1);
    #1 chk("step_settle", out_data, 16);

    // Enable drop when the phase is 2.
    while (e % R != 2) cycle(1, 1, 1);
    cycle(0, 1, 1);
    #1;
    chk("drop_out_valid", out_valid, 0);
    chk("drop_out_data", out_data, 0);
    repeat (41) cycle(1, 1, 1);
    #1 chk("restep_settle", out_data, 16);

    // Asynchronous reset while in_ready is high.
    while (e % R != R - 1) cycle(1, 1, 1);
    do_reset();

    // Impulse.
    mon_sum = 0;
    mon_n = 0;
    first_nz = -1;
    repeat (R) cycle(1, 1, 1);
    repeat (40) cycle(1, 1, 0);
    chk("impulse_sum", mon_sum, 64);
    chk("impulse_first", first_nz, 6);

    // Single missed slot.
    repeat (R - 1) cycle(1, 1, 7);
    cycle(1, 0, 7);
    repeat (20) cycle(1, 1, 7);
    #1 chk("underflow_set", underflow, 1);
    cycle(0, 1, 7);
    repeat (12) cycle(1, 1, -3);
    #1 chk("underflow_sticky", underflow, 1);

    // Randomized traffic.
    for (int t = 0; t < 2500; t++) begin
      bit en;
      bit v;
      int d;
      en = ($urandom % 60) != 0;
      v  = ($urandom % 12) != 0;
      d  = $urandom_range(0, 65535) - 32768;
      cycle(en, v, d);
    end

`ifdef CIC3_INTERP_UNDERFLOW_CNT_EN
    do_reset();
    #1 chk("cnt_reset", ucnt, 0);
    repeat (10 * R) cycle(1, 0, 0);
    #1 chk("cnt_10", ucnt, 10);
    repeat (290 * R) cycle(1, 0, 0);
    #1 chk("cnt_sat", ucnt, 255);
`endif

    cycle(0, 0, 0);
    @(negedge clk);

    // Full-scale negative DC on the R=256 instance.
    en2 = 1'b1;
    v2  = 1'b1;
    d2  = 16'h8000;
    repeat (1100) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("fs_out", out2, -64'sd2147483648);
      @(negedge clk);
    end
    chk("fs_valid", ov2, 1);
    chk("fs_underflow", uf2, 0);
    en2 = 1'b0;
    @(negedge clk);
    #1 chk("fs_cleared", out2, 0);

    chk("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
